viterbi_frame_ctrl: RTL



---
 rtl/viterbi_pkg.sv | 19 +
 rtl/vd_bit_packer.sv | 68 ++++++
 rtl/viterbi_frame_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/viterbi_pkg.sv
// Shared types and constants for the Viterbi frame controller.
// Holds the controller state encoding and the K=3 code definition.
package viterbi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        DONE
    } state_e;

    localparam int K            = 3;
    localparam int TAIL_LEN_DEF = K - 1;

    localparam logic [K-1:0] G1 = 3'b111;
    localparam logic [K-1:0] G2 = 3'b101;

endpackage

// File: rtl/vd_bit_packer.sv
// Serial-in word packer: first bit lands in the MSB.
// A last or flush request emits a partial word left-aligned, zero-padded.
module vd_bit_packer #(
    parameter int OUT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_bit_valid,
    input  logic             i_bit,
    input  logic             i_last,
    input  logic             i_flush,
    output logic             o_word_valid,
    output logic [OUT_W-1:0] o_word,
    output logic             o_word_last
);

    localparam int CW = $clog2(OUT_W + 1);

    logic [OUT_W-1:0] sr_q, sr_d, sr_n;
    logic [OUT_W-1:0] word_q, word_d;
    logic [CW-1:0]    cnt_q, cnt_d, cnt_n, sh;
    logic             vld_q, vld_d;
    logic             last_q, last_d;
    logic             emit;

    always_comb begin
        sr_n  = sr_q;
        cnt_n = cnt_q;
        if (i_bit_valid) begin
            sr_n  = {sr_q[OUT_W-2:0], i_bit};
            cnt_n = cnt_q + 1'b1;
        end
        emit   = (cnt_n == CW'(OUT_W)) ||
                 ((i_last || i_flush) && (cnt_n != '0));
        sh     = CW'(OUT_W) - cnt_n;
        vld_d  = emit;
        last_d = emit && (i_last || i_flush);
        word_d = word_q;
        sr_d   = sr_n;
        cnt_d  = cnt_n;
        if (emit) begin
            word_d = sr_n << sh;
            sr_d   = '0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sr_q   <= '0;
            cnt_q  <= '0;
            word_q <= '0;
            vld_q  <= 1'b0;
            last_q <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            cnt_q  <= cnt_d;
            word_q <= word_d;
            vld_q  <= vld_d;
            last_q <= last_d;
        end
    end

    assign o_word_valid = vld_q;
    assign o_word       = word_q;
    assign o_word_last  = last_q;

endmodule

// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer around a K=3 Viterbi core: clears the decoder, feeds
// symbol pairs, packs info decisions and reports done / drain timeout.
module viterbi_frame_ctrl
    import viterbi_pkg::*;
#(
    parameter int FRAME_LEN_W = 8,
    parameter int TAIL_LEN    = 2,
    parameter int OUT_W       = 8,
    parameter int CLR_CYCLES  = 2,
    parameter int DRAIN_TO    = 64
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic [FRAME_LEN_W-1:0] i_frame_len,
    input  logic                   i_sym_valid,
    input  logic [1:0]             i_sym_data,
    output logic                   o_sym_ready,
    output logic                   o_dec_rst_n,
    output logic                   o_dec_valid,
    output logic [1:0]             o_dec_data,
    input  logic                   i_dec_decision,
    input  logic                   i_dec_valid,
    output logic                   o_word_valid,
    output logic [OUT_W-1:0]       o_word,
    output logic                   o_word_last,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_err
);

    localparam int CNT_W = FRAME_LEN_W + 2;
    localparam int TMR_W = $clog2(DRAIN_TO + 1);
    localparam int CLR_W = $clog2(CLR_CYCLES + 1);

    state_e                 state_q, state_d;
    logic [FRAME_LEN_W-1:0] n_q, n_d;
    logic [CNT_W-1:0]       sym_cnt_q, sym_cnt_d;
    logic [CNT_W-1:0]       dec_cnt_q, dec_cnt_d;
    logic [CNT_W-1:0]       total, n_ext;
    logic [CLR_W-1:0]       clr_q, clr_d;
    logic [TMR_W-1:0]       tmr_q, tmr_d;
    logic                   dec_rst_n_q, dec_rst_n_d;
    logic                   dec_valid_q, dec_valid_d;
    logic [1:0]             dec_data_q, dec_data_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   xfer, dec_acc, pack_vld, pack_last, flush;

    assign n_ext       = CNT_W'(n_q);
    assign total       = n_ext + CNT_W'(TAIL_LEN);
    assign o_sym_ready = (state_q == FEED);
    assign xfer        = i_sym_valid && o_sym_ready;

    // Decisions beyond the frame total are dropped, not counted.
    assign dec_acc   = i_dec_valid && (dec_cnt_q < total) &&
                       ((state_q == FEED) || (state_q == DRAIN));
    assign pack_vld  = dec_acc && (dec_cnt_q < n_ext);
    assign pack_last = pack_vld && (dec_cnt_q == n_ext - CNT_W'(1));

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        sym_cnt_d   = sym_cnt_q;
        dec_cnt_d   = dec_cnt_q + (dec_acc ? CNT_W'(1) : CNT_W'(0));
        clr_d       = clr_q;
        tmr_d       = tmr_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        flush       = 1'b0;
        dec_valid_d = xfer;
        dec_data_d  = xfer ? i_sym_data : dec_data_q;
        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    if (i_frame_len != '0) begin
                        n_d       = i_frame_len;
                        sym_cnt_d = '0;
                        dec_cnt_d = '0;
                        clr_d     = '0;
                        state_d   = CLEAR;
                    end else begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end
                end
            end
            CLEAR: begin
                if (clr_q == CLR_W'(CLR_CYCLES - 1)) state_d = FEED;
                else clr_d = clr_q + 1'b1;
            end
            FEED: begin
                tmr_d = '0;
                if (xfer) begin
                    sym_cnt_d = sym_cnt_q + 1'b1;
                    if (sym_cnt_d == total) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (dec_cnt_d == total) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (tmr_q == TMR_W'(DRAIN_TO - 1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    flush   = 1'b1;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        dec_rst_n_d = (state_d != CLEAR);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            n_q         <= '0;
            sym_cnt_q   <= '0;
            dec_cnt_q   <= '0;
            clr_q       <= '0;
            tmr_q       <= '0;
            dec_rst_n_q <= 1'b0;
            dec_valid_q <= 1'b0;
            dec_data_q  <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            sym_cnt_q   <= sym_cnt_d;
            dec_cnt_q   <= dec_cnt_d;
            clr_q       <= clr_d;
            tmr_q       <= tmr_d;
            dec_rst_n_q <= dec_rst_n_d;
            dec_valid_q <= dec_valid_d;
            dec_data_q  <= dec_data_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    vd_bit_packer #(
        .OUT_W(OUT_W)
    ) u_packer (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_bit_valid  (pack_vld),
        .i_bit        (i_dec_decision),
        .i_last       (pack_last),
        .i_flush      (flush),
        .o_word_valid (o_word_valid),
        .o_word       (o_word),
        .o_word_last  (o_word_last)
    );

    assign o_dec_rst_n = dec_rst_n_q;
    assign o_dec_valid = dec_valid_q;
    assign o_dec_data  = dec_data_q;
    assign o_busy      = (state_q != IDLE);
    assign o_done      = done_q;
    assign o_err       = err_q;

endmodule
